// File: rtl/ascon_pack.sv
// ascon_pack: shared ASCON-AEAD128 types, constants and round-constant helper
package ascon_pack;
  typedef enum logic [2:0] {IDLE, INIT, AD_WAIT, AD_PERM, MSG_WAIT, MSG_PERM, FINAL, DONE} type_aead_state;
  localparam logic [63:0] DSEP = 64'h8000_0000_0000_0000;
  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;
  localparam logic [63:0] IV_AEAD128 = 64'h0000_1000_808c_0001;
  function automatic logic [7:0] rc(input logic [3:0] round);
    return {4'hf - round, round};
  endfunction
endpackage

// File: rtl/ascon_round_unrolled.sv
// ascon_round_unrolled: UNROLL combinational ASCON permutation rounds starting at a given round index
module ascon_round_unrolled
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic [4:0][63:0] state,
  input  logic [3:0]       round,
  output logic [4:0][63:0] result
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [4:0][63:0] perm_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [4:0][63:0] x, t;
    x = s;
    x[2] = x[2] ^ {56'd0, rc(r)};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    t = ~x & {x[0], x[4:1]};
    x = x ^ {t[0], t[4:1]};
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
    x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
    x[2] = x[2] ^ ror(x[2], 1) ^ ror(x[2], 6);
    x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
    x[4] = x[4] ^ ror(x[4], 7) ^ ror(x[4], 41);
    return x;
  endfunction
  always_comb begin
    result = state;
    for (int i = 0; i < UNROLL; i++) result = perm_round(result, round + 4'(i));
  end
endmodule

// File: rtl/ascon_aead_engine.sv
// ascon_aead_engine: streamed ASCON-AEAD128 encrypt/decrypt with valid/ready input and on-chip tag check
module ascon_aead_engine
  import ascon_pack::*;
#(
  parameter int          UNROLL = 1,
  parameter logic [63:0] IV     = IV_AEAD128
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_type_i,
  input  logic         in_last_i,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  output logic [127:0] out_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] tag_o,
  output logic         tag_ok_o,
  output logic         err_o
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("UNROLL must be 1, 2 or 4");
  end
  localparam logic [3:0] LAST_RND = 4'(ROUNDS_A - UNROLL);
  type_aead_state state;
  logic [4:0][63:0] s, p, msg_s;
  logic [3:0] rnd;
  logic dec, ad_last, xfer, perm_done;
  logic [127:0] key, tag_exp, rate, tag_calc;
  ascon_round_unrolled #(.UNROLL(UNROLL)) u_round (.state(s), .round(rnd), .result(p));
  assign in_ready_o = state == AD_WAIT || state == MSG_WAIT;
  assign busy_o = state != IDLE;
  assign xfer = in_valid_i && in_ready_o;
  assign perm_done = rnd == LAST_RND;
  assign rate = {s[0], s[1]} ^ data_i;
  assign tag_calc = {s[3] ^ key[127:64], s[4] ^ key[63:0]};
  always_comb begin
    msg_s = s;
    {msg_s[0], msg_s[1]} = dec ? data_i : rate;
    msg_s[2] = s[2] ^ (in_last_i ? key[127:64] : 64'd0);
    msg_s[3] = s[3] ^ (in_last_i ? key[63:0] : 64'd0);
    msg_s[4] = s[4] ^ (state == AD_WAIT ? DSEP : 64'd0);
  end
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state <= IDLE;
      s <= '0;
      rnd <= '0;
      dec <= 1'b0;
      ad_last <= 1'b0;
      key <= '0;
      tag_exp <= '0;
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      done_o <= 1'b0;
      tag_o <= '0;
      tag_ok_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state <= INIT;
          dec <= decrypt_i;
          key <= key_i;
          tag_exp <= tag_i;
          s <= {nonce_i[63:0], nonce_i[127:64], key_i[63:0], key_i[127:64], IV};
          rnd <= '0;
          err_o <= 1'b0;
          tag_o <= '0;
          tag_ok_o <= 1'b0;
        end
        INIT, AD_PERM, MSG_PERM, FINAL: begin
          s <= p;
          rnd <= rnd + 4'(UNROLL);
          if (perm_done) begin
            if (state == INIT) s <= {p[4] ^ key[63:0], p[3] ^ key[127:64], p[2:0]};
            if (state == AD_PERM && ad_last) s[4] <= p[4] ^ DSEP;
            state <= state == INIT ? AD_WAIT : state == FINAL ? DONE :
                     state == MSG_PERM || ad_last ? MSG_WAIT : AD_WAIT;
          end
        end
        AD_WAIT, MSG_WAIT: if (xfer) begin
          if (!in_type_i && state == MSG_WAIT) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else if (!in_type_i) begin
            s[0] <= rate[127:64];
            s[1] <= rate[63:0];
            ad_last <= in_last_i;
            rnd <= 4'(ROUNDS_A - ROUNDS_B);
            state <= AD_PERM;
          end else begin
            s <= msg_s;
            out_valid_o <= 1'b1;
            out_data_o <= rate;
            rnd <= in_last_i ? 4'd0 : 4'(ROUNDS_A - ROUNDS_B);
            state <= in_last_i ? FINAL : MSG_PERM;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          tag_o <= tag_calc;
          tag_ok_o <= dec && tag_calc == tag_exp;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_aead_engine.sv
// tb_ascon_aead_engine: randomized check of three unroll variants against a table-driven ASCON model
module tb_ascon_aead_engine;
  localparam logic [127:0] KAT_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_N = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetb [3], start [3], decrypt [3], in_valid [3], in_type [3], in_last [3];
  logic [127:0] key [3], nonce [3], tag_in [3], data [3];
  logic in_ready [3], out_valid [3], busy [3], done [3], tag_ok [3], err [3];
  logic [127:0] out_data [3], tag_o [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ascon_aead_engine #(.UNROLL(1 << g)) u_dut (
      .clock_i(clk), .resetb_i(resetb[g]), .start_i(start[g]), .decrypt_i(decrypt[g]),
      .key_i(key[g]), .nonce_i(nonce[g]), .tag_i(tag_in[g]), .in_valid_i(in_valid[g]),
      .in_ready_o(in_ready[g]), .in_type_i(in_type[g]), .in_last_i(in_last[g]), .data_i(data[g]),
      .out_valid_o(out_valid[g]), .out_data_o(out_data[g]), .busy_o(busy[g]), .done_o(done[g]),
      .tag_o(tag_o[g]), .tag_ok_o(tag_ok[g]), .err_o(err[g])
    );
  end
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [127:0] ad_q [$], msg_q [$], exp_q [$], got_q [$];
  logic [127:0] exp_tag;
  logic exp_ok;
  logic [63:0] ms [5];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction
  task automatic model_perm(input int rounds);
    logic [4:0] col;
    for (int r = 12 - rounds; r < 12; r++) begin
      ms[2] ^= {56'd0, 8'hf0 - 8'(r * 15)};
      for (int j = 0; j < 64; j++) begin
        col = {ms[0][j], ms[1][j], ms[2][j], ms[3][j], ms[4][j]};
        {ms[0][j], ms[1][j], ms[2][j], ms[3][j], ms[4][j]} = SBOX[col];
      end
      ms[0] = ms[0] ^ rotr(ms[0], 19) ^ rotr(ms[0], 28);
      ms[1] = ms[1] ^ rotr(ms[1], 61) ^ rotr(ms[1], 39);
      ms[2] = ms[2] ^ rotr(ms[2], 1) ^ rotr(ms[2], 6);
      ms[3] = ms[3] ^ rotr(ms[3], 10) ^ rotr(ms[3], 17);
      ms[4] = ms[4] ^ rotr(ms[4], 7) ^ rotr(ms[4], 41);
    end
  endtask
  task automatic model(input logic dec, input logic [127:0] k, input logic [127:0] n, input logic [127:0] t);
    logic [127:0] c;
    exp_q.delete();
    ms[0] = 64'h0000_1000_808c_0001;
    {ms[1], ms[2]} = k;
    {ms[3], ms[4]} = n;
    model_perm(12);
    ms[3] ^= k[127:64];
    ms[4] ^= k[63:0];
    foreach (ad_q[i]) begin
      {ms[0], ms[1]} = {ms[0], ms[1]} ^ ad_q[i];
      model_perm(8);
    end
    ms[4] ^= 64'h8000_0000_0000_0000;
    foreach (msg_q[i]) begin
      c = {ms[0], ms[1]} ^ msg_q[i];
      exp_q.push_back(c);
      {ms[0], ms[1]} = dec ? msg_q[i] : c;
      if (i < msg_q.size() - 1) model_perm(8);
    end
    ms[2] ^= k[127:64];
    ms[3] ^= k[63:0];
    model_perm(12);
    exp_tag = {ms[3], ms[4]} ^ k;
    exp_ok = dec && exp_tag == t;
  endtask
  task automatic wait_ready(input int u);
    for (int g = 0; g < 100 && !in_ready[u]; g++) step();
  endtask
  task automatic drive(input int u, input logic is_msg, input logic last, input logic [127:0] blk);
    in_valid[u] = 1'b1;
    in_type[u] = is_msg;
    in_last[u] = last;
    data[u] = blk;
  endtask
  task automatic run_op(input int u, input logic dec, input logic [127:0] k, input logic [127:0] n,
                        input logic [127:0] t, input logic early);
    int pa, pb, t_x, rdy_exp, nad, nmsg, g;
    logic is_msg, last;
    logic [127:0] blk;
    model(dec, k, n, t);
    got_q.delete();
    pa = 12 >> u;
    pb = 8 >> u;
    nad = ad_q.size();
    nmsg = msg_q.size();
    start[u] = 1'b1;
    decrypt[u] = dec;
    key[u] = k;
    nonce[u] = n;
    tag_in[u] = t;
    cyc = 0;
    step();
    start[u] = 1'b0;
    check("busy_after_start", 128'(busy[u]), 128'(1));
    check("err_clear_on_start", 128'(err[u]), 128'(0));
    rdy_exp = pa + 1;
    t_x = 0;
    for (int b = 0; b < nad + nmsg; b++) begin
      is_msg = b >= nad;
      blk = is_msg ? msg_q[b - nad] : ad_q[b];
      last = is_msg ? b == nad + nmsg - 1 : b == nad - 1;
      if (early) drive(u, is_msg, last, blk);
      wait_ready(u);
      check("ready_cycle", 128'(cyc), 128'(rdy_exp));
      if (!early) repeat ($urandom_range(0, 2)) step();
      drive(u, is_msg, last, blk);
      t_x = cyc;
      step();
      in_valid[u] = 1'b0;
      check("out_valid", 128'(out_valid[u]), 128'(is_msg));
      check("ready_low_after_xfer", 128'(in_ready[u]), 128'(0));
      if (is_msg) begin
        check("out_data", out_data[u], exp_q[b - nad]);
        got_q.push_back(out_data[u]);
      end
      rdy_exp = t_x + pb + 1;
    end
    for (g = 0; g < 100 && !done[u]; g++) step();
    check("done_cycle", 128'(cyc), 128'(t_x + pa + 2));
    check("tag", tag_o[u], exp_tag);
    check("tag_ok", 128'(tag_ok[u]), 128'(exp_ok));
    check("err_idle", 128'(err[u]), 128'(0));
    step();
    check("done_one_cycle", 128'(done[u]), 128'(0));
    check("tag_held", tag_o[u], exp_tag);
  endtask
  initial begin
    logic [127:0] kat_ct [$], pt [$], kat_tag, k, n;
    logic saw_done;
    for (int i = 0; i < 3; i++) begin
      resetb[i] = 1'b0; start[i] = 1'b0; decrypt[i] = 1'b0; in_valid[i] = 1'b0;
      in_type[i] = 1'b0; in_last[i] = 1'b0; key[i] = '0; nonce[i] = '0; tag_in[i] = '0; data[i] = '0;
    end
    repeat (2) step();
    for (int i = 0; i < 3; i++) resetb[i] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("reset_flags", 128'({in_ready[i], out_valid[i], busy[i], done[i], tag_ok[i], err[i]}), 128'(0));
      check("reset_data", out_data[i] | tag_o[i], 128'(0));
    end
    ad_q = '{128'h00112233445566778899aabbccddeeff};
    pt = '{128'h0f0e0d0c0b0a09080706050403020100, 128'hdeadbeefcafef00d0123456789abcdef};
    msg_q = pt;
    run_op(0, 1'b0, KAT_K, KAT_N, '0, 1'b0);
    kat_ct = exp_q;
    kat_tag = exp_tag;
    msg_q = kat_ct;
    run_op(0, 1'b1, KAT_K, KAT_N, kat_tag, 1'b0);
    check("dec_pt0", got_q[0], pt[0]);
    check("dec_pt1", got_q[1], pt[1]);
    check("dec_tag_ok", 128'(tag_ok[0]), 128'(1));
    run_op(0, 1'b1, KAT_K, KAT_N, kat_tag ^ 128'd1, 1'b1);
    check("dec_bad_pt0", got_q[0], pt[0]);
    check("dec_bad_tag_ok", 128'(tag_ok[0]), 128'(0));
    ad_q.delete();
    msg_q = '{rnd128()};
    run_op(0, 1'b0, KAT_K, KAT_N, '0, 1'b0);
    ad_q = '{rnd128(), rnd128(), rnd128()};
    msg_q = '{rnd128(), rnd128(), rnd128()};
    k = rnd128();
    n = rnd128();
    for (int u = 0; u < 3; u++) run_op(u, 1'b0, k, n, '0, u == 2);
    ad_q = '{rnd128()};
    msg_q = '{rnd128(), rnd128()};
    start[0] = 1'b1; key[0] = KAT_K; nonce[0] = KAT_N; decrypt[0] = 1'b0;
    step();
    start[0] = 1'b0;
    wait_ready(0);
    drive(0, 1'b1, 1'b0, msg_q[0]);
    step();
    in_valid[0] = 1'b0;
    wait_ready(0);
    drive(0, 1'b0, 1'b0, ad_q[0]);
    step();
    in_valid[0] = 1'b0;
    check("proto_err", 128'(err[0]), 128'(1));
    check("proto_err_busy", 128'(busy[0]), 128'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      saw_done |= done[0];
      step();
    end
    check("proto_err_no_done", 128'(saw_done), 128'(0));
    check("proto_err_sticky", 128'(err[0]), 128'(1));
    ad_q = '{128'h00112233445566778899aabbccddeeff};
    msg_q = pt;
    run_op(0, 1'b0, KAT_K, KAT_N, '0, 1'b0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_ready(0);
    drive(0, 1'b1, 1'b0, pt[0]);
    step();
    in_valid[0] = 1'b0;
    resetb[0] = 1'b0;
    step();
    resetb[0] = 1'b1;
    check("midop_reset_flags", 128'({in_ready[0], out_valid[0], busy[0], done[0], tag_ok[0], err[0]}), 128'(0));
    check("midop_reset_data", out_data[0] | tag_o[0], 128'(0));
    run_op(0, 1'b0, KAT_K, KAT_N, '0, 1'b1);
    check("kat_after_reset_tag", tag_o[0], kat_tag);
    check("kat_after_reset_ct1", got_q[1], kat_ct[1]);
    for (int it = 0; it < 6; it++) begin
      ad_q.delete();
      msg_q.delete();
      repeat ($urandom_range(0, 3)) ad_q.push_back(rnd128());
      repeat ($urandom_range(1, 3)) msg_q.push_back(rnd128());
      run_op(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(),
             1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
